// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and width shared by the execute-stage ALU
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SLT   = 5'd3,
    OP_SLTU  = 5'd4,
    OP_XOR   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_OR    = 5'd8,
    OP_AND   = 5'd9,
    OP_BEQ   = 5'd10,
    OP_BNE   = 5'd11,
    OP_BLT   = 5'd12,
    OP_BGE   = 5'd13,
    OP_BLTU  = 5'd14,
    OP_BGEU  = 5'd15,
    OP_PASSB = 5'd16
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational logical/arithmetic shifts with a 5-bit amount
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      shamt_i,
  output logic [XLEN-1:0] sll_o,
  output logic [XLEN-1:0] srl_o,
  output logic [XLEN-1:0] sra_o
);

  assign sll_o = data_i << shamt_i;
  assign srl_o = data_i >> shamt_i;
  assign sra_o = $signed(data_i) >>> shamt_i;

endmodule

// File: rtl/alu_top.sv
// rtl/alu_top.sv - registered RV32I integer ALU with result flags and ready handshake
module alu_top
  import alu_pkg::*;
(
  input  logic            soc_clk,
  input  logic            reset,
  input  logic            dat_ready,
  input  logic [XLEN-1:0] ALU_dat1,
  input  logic [XLEN-1:0] ALU_dat2,
  input  logic [4:0]      Instruction_to_ALU,
  output logic [XLEN-1:0] ALU_out,
  output logic            ALU_overflow,
  output logic            ALU_zero,
  output logic            ALU_con_met,
  output logic            ALU_err,
  output logic            ALU_ready
);

  alu_op_e         op;
  logic [XLEN-1:0] sum, diff, sll_res, srl_res, sra_res;
  logic            lt_s, lt_u, eq;

  logic [XLEN-1:0] out_d, out_q;
  logic            ovf_d, ovf_q, zero_d, zero_q, con_d, con_q, err_d, err_q, ready_q;

  assign op   = alu_op_e'(Instruction_to_ALU);
  assign sum  = ALU_dat1 + ALU_dat2;
  assign diff = ALU_dat1 - ALU_dat2;
  assign lt_s = $signed(ALU_dat1) < $signed(ALU_dat2);
  assign lt_u = ALU_dat1 < ALU_dat2;
  assign eq   = ALU_dat1 == ALU_dat2;

  alu_shifter u_shifter (
    .data_i  (ALU_dat1),
    .shamt_i (ALU_dat2[4:0]),
    .sll_o   (sll_res),
    .srl_o   (srl_res),
    .sra_o   (sra_res)
  );

  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    con_d = 1'b0;
    err_d = 1'b0;
    case (op)
      OP_ADD: begin
        out_d = sum;
        ovf_d = (ALU_dat1[XLEN-1] == ALU_dat2[XLEN-1]) && (sum[XLEN-1] != ALU_dat1[XLEN-1]);
      end
      OP_SUB: begin
        out_d = diff;
        ovf_d = (ALU_dat1[XLEN-1] != ALU_dat2[XLEN-1]) && (diff[XLEN-1] != ALU_dat1[XLEN-1]);
      end
      OP_SLL:   out_d = sll_res;
      OP_SRL:   out_d = srl_res;
      OP_SRA:   out_d = sra_res;
      OP_XOR:   out_d = ALU_dat1 ^ ALU_dat2;
      OP_OR:    out_d = ALU_dat1 | ALU_dat2;
      OP_AND:   out_d = ALU_dat1 & ALU_dat2;
      OP_PASSB: out_d = ALU_dat2;
      OP_SLT,  OP_BLT:  con_d = lt_s;
      OP_SLTU, OP_BLTU: con_d = lt_u;
      OP_BGE:  con_d = !lt_s;
      OP_BGEU: con_d = !lt_u;
      OP_BEQ:  con_d = eq;
      OP_BNE:  con_d = !eq;
      default: err_d = 1'b1;
    endcase
    // compare ops report their condition as a 0/1 result word
    if (con_d) out_d = {{(XLEN-1){1'b0}}, 1'b1};
    zero_d = (out_d == '0);
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      con_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else if (dat_ready) begin
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      con_q   <= con_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b0;
    end
  end

  assign ALU_out      = out_q;
  assign ALU_overflow = ovf_q;
  assign ALU_zero     = zero_q;
  assign ALU_con_met  = con_q;
  assign ALU_err      = err_q;
  assign ALU_ready    = ready_q;

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - directed and randomized checks of alu_top against an arithmetic reference model
module tb_alu_top;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        zero;
    logic        con;
    logic        err;
  } res_t;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        dat_ready;
  logic [31:0] dat1, dat2;
  logic [4:0]  op;
  logic [31:0] alu_out;
  logic        alu_ovf, alu_zero, alu_con, alu_err, alu_ready;

  int   compared   = 0;
  int   mismatched = 0;
  res_t last;

  always #5 soc_clk = ~soc_clk;

  alu_top dut (
    .soc_clk            (soc_clk),
    .reset              (reset),
    .dat_ready          (dat_ready),
    .ALU_dat1           (dat1),
    .ALU_dat2           (dat2),
    .Instruction_to_ALU (op),
    .ALU_out            (alu_out),
    .ALU_overflow       (alu_ovf),
    .ALU_zero           (alu_zero),
    .ALU_con_met        (alu_con),
    .ALU_err            (alu_err),
    .ALU_ready          (alu_ready)
  );

  function automatic res_t model(input int code, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa, sb, ua, ub, t;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b % 32);
    r.out = 32'd0; r.ovf = 1'b0; r.con = 1'b0; r.err = 1'b0;
    case (code)
      0:  begin t = sa + sb; r.out = t[31:0]; r.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      1:  begin t = sa - sb; r.out = t[31:0]; r.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      2:  begin t = ua * (64'sd1 << sh); r.out = t[31:0]; end
      3:  r.con = sa < sb;
      4:  r.con = ua < ub;
      5:  r.out = a ^ b;
      6:  begin t = ua / (64'sd1 << sh); r.out = t[31:0]; end
      7:  begin t = sa >>> sh; r.out = t[31:0]; end
      8:  r.out = a | b;
      9:  r.out = a & b;
      10: r.con = sa == sb;
      11: r.con = sa != sb;
      12: r.con = sa < sb;
      13: r.con = sa >= sb;
      14: r.con = ua < ub;
      15: r.con = ua >= ub;
      16: r.out = b;
      default: r.err = 1'b1;
    endcase
    if (code == 3 || code == 4 || (code >= 10 && code <= 15)) r.out = {31'd0, r.con};
    r.zero = (r.out == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input res_t e, input logic rdy);
    chk({tag, " out"},   alu_out,   e.out);
    chk({tag, " ovf"},   alu_ovf,   e.ovf);
    chk({tag, " zero"},  alu_zero,  e.zero);
    chk({tag, " con"},   alu_con,   e.con);
    chk({tag, " err"},   alu_err,   e.err);
    chk({tag, " ready"}, alu_ready, rdy);
  endtask

  task automatic apply(input string tag, input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge soc_clk);
    op = code; dat1 = a; dat2 = b; dat_ready = 1'b1;
    @(posedge soc_clk);
    #1;
    last = model(int'(code), a, b);
    chk_all(tag, last, 1'b1);
  endtask

  task automatic idle(input string tag);
    @(negedge soc_clk);
    dat_ready = 1'b0;
    op = 5'($urandom); dat1 = $urandom; dat2 = $urandom;
    @(posedge soc_clk);
    #1;
    chk_all(tag, last, 1'b0);
  endtask

  initial begin
    res_t zero_res;
    zero_res.out = 32'd0; zero_res.ovf = 1'b0; zero_res.zero = 1'b0;
    zero_res.con = 1'b0;  zero_res.err = 1'b0;

    reset = 1'b1; dat_ready = 1'b0; op = 5'd0; dat1 = 32'd0; dat2 = 32'd0;
    repeat (2) @(posedge soc_clk);
    #1;
    chk_all("reset", zero_res, 1'b0);
    @(negedge soc_clk);
    reset = 1'b0;

    apply("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf literal", alu_out, 32'h8000_0000);
    idle("add_hold");
    apply("sub_zero", 5'd1, 32'd5, 32'd5);
    apply("sub_ovf", 5'd1, 32'h8000_0000, 32'd1);
    chk("sub_ovf literal", alu_out, 32'h7FFF_FFFF);
    apply("sra", 5'd7, 32'h8000_0000, 32'h24);
    chk("sra literal", alu_out, 32'hF800_0000);
    apply("srl", 5'd6, 32'h8000_0000, 32'h24);
    chk("srl literal", alu_out, 32'h0800_0000);
    apply("sll", 5'd2, 32'd1, 32'd31);
    apply("blt", 5'd12, 32'hFFFF_FFFF, 32'd1);
    chk("blt literal", alu_con, 1'b1);
    apply("bltu", 5'd14, 32'hFFFF_FFFF, 32'd1);
    chk("bltu literal", alu_zero, 1'b1);
    apply("beq", 5'd10, 32'd7, 32'd7);
    apply("undef", 5'h1F, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("undef literal", alu_err, 1'b1);
    apply("add_after_err", 5'd0, 32'd2, 32'd3);
    chk("add_after_err literal", alu_out, 32'd5);

    // asynchronous reset while ready is high, checked before the next edge
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", zero_res, 1'b0);
    @(negedge soc_clk);
    op = 5'd5; dat1 = 32'h0000_F0F0; dat2 = 32'h0000_FF00; dat_ready = 1'b1;
    #2 reset = 1'b0;
    @(posedge soc_clk);
    #1;
    last = model(5, 32'h0000_F0F0, 32'h0000_FF00);
    chk_all("xor_after_reset", last, 1'b1);
    chk("xor_after_reset literal", alu_out, 32'h0000_0FF0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) idle("rand_idle");
      else apply("rand", 5'($urandom_range(0, 31)), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
